// File: rtl/axi_burst_dram_master.sv
// AXI4 INCR burst master: independent write (AW/W/B) and read (AR/R) engines, 1-256 beats.
// Define DRAM_BOUNDARY_CHECK_EN to reject misaligned or 4 KB-crossing requests at IDLE.
module axi_burst_dram_master #(
   parameter int AXI_ADDR_WIDTH   = 32,
   parameter int AXI_DATA_WIDTH   = 512,
   parameter int AXI_ID_WIDTH     = 16,
   parameter int AXI_ID_VALUE     = 0,
   parameter int AXI_STROBE_WIDTH = AXI_DATA_WIDTH/8,
   parameter int AXI_SIZE         = $clog2(AXI_STROBE_WIDTH)
) (
   input  logic                        m_axi_aclk,
   input  logic                        m_axi_aresetn,
   output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [AXI_ID_WIDTH-1:0]     m_axi_awid,
   output logic [1:0]                  m_axi_awburst,
   output logic [2:0]                  m_axi_awsize,
   output logic [7:0]                  m_axi_awlen,
   output logic                        m_axi_awvalid,
   output logic [AXI_ID_WIDTH-1:0]     m_axi_awuser,
   input  logic                        m_axi_awready,
   output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [AXI_STROBE_WIDTH-1:0] m_axi_wstrb,
   output logic                        m_axi_wvalid,
   output logic                        m_axi_wlast,
   input  logic                        m_axi_wready,
   output logic                        m_axi_bready,
   input  logic [1:0]                  m_axi_bresp,
   input  logic                        m_axi_bvalid,
   input  logic [AXI_ID_WIDTH-1:0]     m_axi_bid,
   output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
   output logic [AXI_ID_WIDTH-1:0]     m_axi_arid,
   output logic [1:0]                  m_axi_arburst,
   output logic [2:0]                  m_axi_arsize,
   output logic [7:0]                  m_axi_arlen,
   output logic                        m_axi_arvalid,
   output logic [AXI_ID_WIDTH-1:0]     m_axi_aruser,
   input  logic                        m_axi_arready,
   output logic                        m_axi_rready,
   input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
   input  logic [1:0]                  m_axi_rresp,
   input  logic                        m_axi_rvalid,
   input  logic                        m_axi_rlast,
   input  logic [AXI_ID_WIDTH-1:0]     m_axi_rid,
   input  logic                        dram_write_req,
   input  logic [AXI_ADDR_WIDTH-1:0]   dram_write_addr,
   input  logic [7:0]                  dram_write_len,
   input  logic [AXI_DATA_WIDTH-1:0]   dram_write_data,
   input  logic                        dram_write_data_valid,
   output logic                        dram_write_data_ready,
   output logic                        dram_write_busy,
   output logic                        dram_write_done,
   output logic                        dram_write_error,
   input  logic                        dram_read_req,
   input  logic [AXI_ADDR_WIDTH-1:0]   dram_read_addr,
   input  logic [7:0]                  dram_read_len,
   output logic [AXI_DATA_WIDTH-1:0]   dram_read_data,
   output logic                        dram_read_data_valid,
   output logic                        dram_read_data_last,
   output logic                        dram_read_busy,
   output logic                        dram_read_done,
   output logic                        dram_read_error
);

   localparam logic [2:0]              SIZE3 = 3'(AXI_SIZE);
   localparam logic [AXI_ID_WIDTH-1:0] ID    = AXI_ID_WIDTH'(AXI_ID_VALUE);

   typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_t;
   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;

   wstate_t                     wstate, wstate_nxt;
   rstate_t                     rstate, rstate_nxt;
   logic [AXI_ADDR_WIDTH-1:0]   waddr_q, raddr_q;
   logic [7:0]                  wlen_q, rlen_q, wcnt, rcnt;
   logic                        w_accept, w_reject, w_beat, w_fin;
   logic                        r_accept, r_reject, r_beat, r_fin;
   logic                        w_rej, r_rej, r_beat_err;
   logic                        unused_ids;

   assign unused_ids = ^{m_axi_bid, m_axi_rid};

`ifdef DRAM_BOUNDARY_CHECK_EN
   // Reject when misaligned or when the burst's last byte lies past the 4 KB page.
   function automatic logic bad_req(input logic [AXI_ADDR_WIDTH-1:0] a, input logic [7:0] l);
      logic [31:0] end_off;
      end_off = 32'(a[11:0]) + ((32'(l) + 32'd1) << AXI_SIZE);
      return (a[AXI_SIZE-1:0] != '0) || (end_off > 32'd4096);
   endfunction
   assign w_rej = bad_req(dram_write_addr, dram_write_len);
   assign r_rej = bad_req(dram_read_addr, dram_read_len);
`else
   assign w_rej = 1'b0;
   assign r_rej = 1'b0;
`endif

   // ---------------- write path ----------------
   always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn)
      if (!m_axi_aresetn) wstate <= W_IDLE;
      else                wstate <= wstate_nxt;

   always_comb begin
      wstate_nxt = wstate;
      w_accept   = 1'b0;
      w_reject   = 1'b0;
      w_beat     = 1'b0;
      w_fin      = 1'b0;
      case (wstate)
         W_IDLE: if (dram_write_req) begin
            if (w_rej) w_reject = 1'b1;
            else begin
               w_accept   = 1'b1;
               wstate_nxt = W_ADDR;
            end
         end
         W_ADDR: if (m_axi_awready) wstate_nxt = W_DATA;
         W_DATA: begin
            w_beat = dram_write_data_valid & m_axi_wready;
            if (w_beat && wcnt == wlen_q) wstate_nxt = W_RESP;
         end
         W_RESP: if (m_axi_bvalid) begin
            w_fin      = 1'b1;
            wstate_nxt = W_IDLE;
         end
         default: wstate_nxt = W_IDLE;
      endcase
   end

   // Fixed AXI fields are gated by valid so reset drives every output to zero.
   assign m_axi_awvalid         = (wstate == W_ADDR);
   assign m_axi_awaddr          = waddr_q;
   assign m_axi_awlen           = wlen_q;
   assign m_axi_awburst         = m_axi_awvalid ? 2'b01 : 2'b00;
   assign m_axi_awsize          = m_axi_awvalid ? SIZE3 : 3'd0;
   assign m_axi_awid            = m_axi_awvalid ? ID : '0;
   assign m_axi_awuser          = '0;
   assign m_axi_wvalid          = (wstate == W_DATA) & dram_write_data_valid;
   assign m_axi_wdata           = (wstate == W_DATA) ? dram_write_data : '0;
   assign m_axi_wstrb           = (wstate == W_DATA) ? '1 : '0;
   assign m_axi_wlast           = (wstate == W_DATA) && (wcnt == wlen_q);
   assign dram_write_data_ready = (wstate == W_DATA) & m_axi_wready;
   assign m_axi_bready          = (wstate == W_RESP);

   always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
      if (!m_axi_aresetn) begin
         waddr_q          <= '0;
         wlen_q           <= '0;
         wcnt             <= '0;
         dram_write_busy  <= 1'b0;
         dram_write_done  <= 1'b0;
         dram_write_error <= 1'b0;
      end else begin
         dram_write_done <= 1'b0;
         if (w_accept) begin
            waddr_q          <= dram_write_addr;
            wlen_q           <= dram_write_len;
            wcnt             <= '0;
            dram_write_busy  <= 1'b1;
            dram_write_error <= 1'b0;
         end
         if (w_reject) begin
            dram_write_done  <= 1'b1;
            dram_write_error <= 1'b1;
         end
         if (w_beat) wcnt <= wcnt + 8'd1;
         if (w_fin) begin
            dram_write_done  <= 1'b1;
            dram_write_error <= (m_axi_bresp != 2'b00);
            dram_write_busy  <= 1'b0;
         end
      end
   end

   // ---------------- read path ----------------
   always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn)
      if (!m_axi_aresetn) rstate <= R_IDLE;
      else                rstate <= rstate_nxt;

   always_comb begin
      rstate_nxt = rstate;
      r_accept   = 1'b0;
      r_reject   = 1'b0;
      r_beat     = 1'b0;
      r_fin      = 1'b0;
      case (rstate)
         R_IDLE: if (dram_read_req) begin
            if (r_rej) r_reject = 1'b1;
            else begin
               r_accept   = 1'b1;
               rstate_nxt = R_ADDR;
            end
         end
         R_ADDR: if (m_axi_arready) rstate_nxt = R_DATA;
         R_DATA: begin
            r_beat = m_axi_rvalid;
            if (m_axi_rvalid && m_axi_rlast) begin
               r_fin      = 1'b1;
               rstate_nxt = R_IDLE;
            end
         end
         default: rstate_nxt = R_IDLE;
      endcase
   end

   assign m_axi_arvalid = (rstate == R_ADDR);
   assign m_axi_araddr  = raddr_q;
   assign m_axi_arlen   = rlen_q;
   assign m_axi_arburst = m_axi_arvalid ? 2'b01 : 2'b00;
   assign m_axi_arsize  = m_axi_arvalid ? SIZE3 : 3'd0;
   assign m_axi_arid    = m_axi_arvalid ? ID : '0;
   assign m_axi_aruser  = '0;
   assign m_axi_rready  = (rstate == R_DATA);

   // A beat is in error on a bad response or when rlast disagrees with the beat count.
   assign r_beat_err = (m_axi_rresp != 2'b00) || (m_axi_rlast != (rcnt == rlen_q));

   always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
      if (!m_axi_aresetn) begin
         raddr_q              <= '0;
         rlen_q               <= '0;
         rcnt                 <= '0;
         dram_read_data       <= '0;
         dram_read_data_valid <= 1'b0;
         dram_read_data_last  <= 1'b0;
         dram_read_busy       <= 1'b0;
         dram_read_done       <= 1'b0;
         dram_read_error      <= 1'b0;
      end else begin
         dram_read_done       <= 1'b0;
         dram_read_data_valid <= r_beat;
         dram_read_data_last  <= r_beat & m_axi_rlast;
         if (r_accept) begin
            raddr_q         <= dram_read_addr;
            rlen_q          <= dram_read_len;
            rcnt            <= '0;
            dram_read_busy  <= 1'b1;
            dram_read_error <= 1'b0;
         end
         if (r_reject) begin
            dram_read_done  <= 1'b1;
            dram_read_error <= 1'b1;
         end
         if (r_beat) begin
            dram_read_data  <= m_axi_rdata;
            rcnt            <= rcnt + 8'd1;
            dram_read_error <= dram_read_error | r_beat_err;
         end
         if (r_fin) begin
            dram_read_done <= 1'b1;
            dram_read_busy <= 1'b0;
         end
      end
   end

endmodule

// File: doc/axi_burst_dram_master.md
# axi_burst_dram_master

Parametrised AXI4 master that sits between the image/ML datapath and the ZCU104 PS DDR port. It issues INCR bursts of 1–256 beats, streams write data in from a valid/ready source, and streams read data out one beat per cycle. Read and write paths are fully independent. Each transaction ends with a done pulse and a per-transaction error flag, so callers no longer have to poll busy.

## Interface
Parameters:
- AXI_ADDR_WIDTH, 32, address width
- AXI_DATA_WIDTH, 512, data width; power of two, 32–1024
- AXI_ID_WIDTH, 16, width of the ID and user fields
- AXI_ID_VALUE, 0, constant driven on awid/arid
- AXI_STROBE_WIDTH, AXI_DATA_WIDTH/8, derived
- AXI_SIZE, $clog2(AXI_STROBE_WIDTH), derived; driven on awsize/arsize

Ports:
- m_axi_aclk  in  1  single clock for everything
- m_axi_aresetn  in  1  asynchronous, active-low reset
- m_axi_aw{addr,id,burst,size,len,valid,user}, m_axi_awready  AXI4 write-address channel
- m_axi_w{data,strb,valid,last}, m_axi_wready  AXI4 write-data channel
- m_axi_b{ready}, m_axi_b{resp,valid,id}  AXI4 write-response channel
- m_axi_ar{addr,id,burst,size,len,valid,user}, m_axi_arready  AXI4 read-address channel
- m_axi_r{ready}, m_axi_r{data,resp,valid,last,id}  AXI4 read-data channel
- dram_write_req  in  1  start a write; sampled only in W_IDLE
- dram_write_addr  in  AXI_ADDR_WIDTH  byte address of the write
- dram_write_len  in  8  write beats minus 1
- dram_write_data  in  AXI_DATA_WIDTH  write beat data
- dram_write_data_valid  in  1  write beat present
- dram_write_data_ready  out  1  write beat consumed this cycle
- dram_write_busy / dram_write_done / dram_write_error  out  1 each  write status
- dram_read_req  in  1  start a read; sampled only in R_IDLE
- dram_read_addr  in  AXI_ADDR_WIDTH  byte address of the read
- dram_read_len  in  8  read beats minus 1
- dram_read_data  out  AXI_DATA_WIDTH  read beat data
- dram_read_data_valid  out  1  read beat present
- dram_read_data_last  out  1  final read beat
- dram_read_busy / dram_read_done / dram_read_error  out  1 each  read status

## Operation
- Both address channels drive burst = 2'b01 (INCR), size = AXI_SIZE, user = 0 and id = AXI_ID_VALUE. wstrb is all ones.
- Write FSM states: W_IDLE → W_ADDR → W_DATA → W_RESP → W_IDLE.
  - W_IDLE, req = 1: register addr/len, assert awvalid and busy, go to W_ADDR.
  - W_ADDR: hold awvalid until awready = 1, then go to W_DATA.
  - W_DATA: the write beat passes through combinationally.
    - m_axi_wvalid = dram_write_data_valid.
    - dram_write_data_ready = m_axi_wready.
    - m_axi_wdata = dram_write_data.
    - An 8-bit beat counter increments on each wvalid&wready handshake.
    - wlast = (counter == len).
    - The handshake carrying wlast moves the FSM to W_RESP.
  - W_RESP: bready = 1. On bvalid: pulse done for 1 cycle; error = (bresp != 0), held until the next req is accepted; clear busy; return to W_IDLE.
- Read FSM states: R_IDLE → R_ADDR → R_DATA → R_IDLE.
  - R_IDLE, req = 1: assert arvalid and busy, go to R_ADDR.
  - R_ADDR: hold arvalid until arready = 1, then go to R_DATA.
  - R_DATA: rready = 1 continuously; there is no downstream backpressure, so the consumer must accept 1 beat per cycle.
    - Each rvalid beat is registered: data, valid = 1, last = rlast.
    - The error accumulator ORs in (rresp != 0) and (rlast != (counter == len)).
    - On the rlast beat: done pulses, busy clears, return to R_IDLE.
- Requests arriving while busy are ignored, not queued.
- Read and write may run in the same cycle with no interaction.

## Timing
- Reset is asynchronous: every output goes to 0 immediately. That includes all valid/ready/last signals, busy, done, error, data and address fields.
- Reset mid-burst abandons the transaction. No AXI cleanup is performed; the interconnect is reset alongside this block.
- Latency from req to awvalid/arvalid: 1 cycle.
- AXI valids, once asserted, stay high and stable until their ready arrives.
- dram_read_data_valid follows the rvalid&rready cycle by exactly 1 cycle.
- done goes high 1 cycle after the final handshake (bvalid for writes, rlast for reads).
- busy drops in the same cycle done goes high. A new req is accepted the cycle after that.
- len = 0: single beat with wlast on the first beat. len = 255: 256 beats; the counter must not wrap before wlast.

## Configuration
- Macro: DRAM_BOUNDARY_CHECK_EN.
- Defined: a req is rejected in the IDLE state, with no AXI traffic, if either condition holds:
  - addr[AXI_SIZE-1:0] != 0 (misaligned), or
  - addr[11:0] + (len+1)·AXI_STROBE_WIDTH > 4096 (crosses a 4 KB boundary).
- On rejection: done and error pulse together, error stays set, busy stays 0.
- Undefined: no check; the address and length are issued as given.

## Test plan
- Write addr 0x1000, len 3, source valid every cycle, awready/wready = 1, bresp = 0 → 4 beats with wlast on beat 4, done 1 cycle after bvalid, error = 0.
- Write len 0 with wready low for 5 cycles → wvalid and wdata held stable; a single beat with wlast; dram_write_data_ready high only in the handshake cycle.
- Read addr 0x2000, len 255, rvalid every cycle → 256 dram_read_data_valid pulses, last on the 256th, done the cycle after it.
- Read with rresp = 2'b10 on beat 2 of 4 → all 4 beats delivered, error = 1 at done.
- Concurrent write and read issued in the same cycle with randomized ready/valid delays → both complete, data matches the memory model, and reset asserted mid-burst zeroes all outputs asynchronously.
- DRAM_BOUNDARY_CHECK_EN defined, 512-bit data, addr 0x0FC0, len 1 → no awvalid, done = error = 1. Without the macro → a 2-beat burst is issued.
